// File: rtl/irq_prio_ctrl.sv
// rtl/irq_prio_ctrl.sv - fixed-priority preemptive interrupt controller with nesting stack
// Optional macro IRQ_PRIO_PREEMPT_EN enables nested preemption; without it only one handler is active.
module irq_prio_ctrl #(
    parameter int          N_SRC      = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0020,
    parameter logic [15:0] VEC_STRIDE = 16'h0020,
    parameter int          MAX_DEPTH  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_irq_src,
    input  logic [N_SRC-1:0] i_irq_en,
    input  logic             i_gie,
    input  logic             i_take_ok,
    input  logic             i_iret,
    input  logic [N_SRC-1:0] i_pend_clr,
    output logic             o_irq_take,
    output logic [15:0]      o_irq_vector,
    output logic             o_in_irq,
    output logic [1:0]       o_irq_depth,
    output logic [N_SRC-1:0] o_pending
);

    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int LW = SW + 1;

`ifdef IRQ_PRIO_PREEMPT_EN
    localparam logic [1:0] DEPTH_LIMIT = 2'(MAX_DEPTH);
`else
    localparam logic [1:0] DEPTH_LIMIT = 2'd1;
`endif

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] set_mask;
    logic [N_SRC-1:0] clr_mask;
    logic [SW-1:0]    stack [MAX_DEPTH];
    logic [1:0]       depth;
    logic [1:0]       top;
    logic [SW-1:0]    cand;
    logic [SW-1:0]    cand_q;
    logic             cand_vld;
    logic [LW-1:0]    cur_lvl;
    logic             issue;
    logic             pop;
    logic             take;
    logic [15:0]      vector;

    assign top = depth - 2'd1;
    assign pop = i_iret && (depth != 2'd0);

    // Levels are source index + 1 so that level 0 means "no handler active".
    always_comb begin
        cur_lvl = '0;
        if (depth != 2'd0) begin
            cur_lvl = LW'(stack[top]) + LW'(1);
        end
    end

    // Later iterations override earlier ones, so the highest eligible index wins.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (pending[k] && i_irq_en[k]) begin
                cand     = SW'(k);
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        issue = i_gie && i_take_ok && cand_vld && !take
                && ((LW'(cand) + LW'(1)) > cur_lvl)
                && (depth < DEPTH_LIMIT);
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    assign set_mask = i_irq_src & ~src_q;
    assign clr_mask = i_pend_clr | (take ? (N_SRC'(1) << cand_q) : '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_q   <= '0;
            pending <= '0;
            depth   <= 2'd0;
            take    <= 1'b0;
            vector  <= 16'h0000;
            cand_q  <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            src_q   <= i_irq_src;
            pending <= set_mask | (pending & ~clr_mask);
            take    <= issue;
            if (issue) begin
                cand_q <= cand;
                vector <= VEC_BASE + VEC_STRIDE * 16'(cand);
            end
            // The take pulse ends here: commit, with a coincident iret popping first.
            if (take && pop) begin
                stack[top] <= cand_q;
            end else if (take) begin
                stack[depth] <= cand_q;
                depth        <= depth + 2'd1;
            end else if (pop) begin
                depth <= depth - 2'd1;
            end
        end
    end

    assign o_irq_take   = take;
    assign o_irq_vector = vector;
    assign o_irq_depth  = depth;
    assign o_in_irq     = (depth != 2'd0);
    assign o_pending    = pending;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb/tb_irq_prio_ctrl.sv - directed and random checks of irq_prio_ctrl against a queue-based model
module tb_irq_prio_ctrl;

    localparam int          N_SRC      = 4;
    localparam logic [15:0] VEC_BASE   = 16'h0020;
    localparam logic [15:0] VEC_STRIDE = 16'h0020;
    localparam int          MAX_DEPTH  = 3;
`ifdef IRQ_PRIO_PREEMPT_EN
    localparam int LIMIT = MAX_DEPTH;
`else
    localparam int LIMIT = 1;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [N_SRC-1:0] i_irq_src;
    logic [N_SRC-1:0] i_irq_en;
    logic             i_gie;
    logic             i_take_ok;
    logic             i_iret;
    logic [N_SRC-1:0] i_pend_clr;
    logic             o_irq_take;
    logic [15:0]      o_irq_vector;
    logic             o_in_irq;
    logic [1:0]       o_irq_depth;
    logic [N_SRC-1:0] o_pending;

    int checks = 0;
    int errors = 0;

    irq_prio_ctrl #(
        .N_SRC(N_SRC), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_irq_src(i_irq_src), .i_irq_en(i_irq_en),
        .i_gie(i_gie), .i_take_ok(i_take_ok), .i_iret(i_iret), .i_pend_clr(i_pend_clr),
        .o_irq_take(o_irq_take), .o_irq_vector(o_irq_vector), .o_in_irq(o_in_irq),
        .o_irq_depth(o_irq_depth), .o_pending(o_pending)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: active handlers held as a queue of source indices.
    bit   m_take;
    int   m_vec;
    int   m_cand;
    bit   m_pend [N_SRC];
    bit   m_srcq [N_SRC];
    int   m_stk [$];

    task automatic model_edge();
        int  cur, cand;
        bit  commit, issue, set_b, clr_b;
        if (i_rst) begin
            m_take = 0; m_vec = 0; m_cand = 0; m_stk.delete();
            for (int k = 0; k < N_SRC; k++) begin m_pend[k] = 0; m_srcq[k] = 0; end
            return;
        end
        commit = m_take;
        cur  = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] + 1 : 0;
        cand = -1;
        for (int k = 0; k < N_SRC; k++) if (m_pend[k] && i_irq_en[k]) cand = k;
        issue = i_gie && i_take_ok && (cand >= 0) && (cand + 1 > cur)
                && (m_stk.size() < LIMIT) && !m_take;
        for (int k = 0; k < N_SRC; k++) begin
            set_b = i_irq_src[k] && !m_srcq[k];
            clr_b = i_pend_clr[k] || (commit && m_cand == k);
            m_pend[k] = set_b ? 1'b1 : (clr_b ? 1'b0 : m_pend[k]);
            m_srcq[k] = i_irq_src[k];
        end
        if (i_iret && m_stk.size() > 0) void'(m_stk.pop_back());
        if (commit) m_stk.push_back(m_cand);
        m_take = issue;
        if (issue) begin
            m_cand = cand;
            m_vec  = (VEC_BASE + cand * VEC_STRIDE) & 16'hFFFF;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N_SRC-1:0] mp;
        for (int k = 0; k < N_SRC; k++) mp[k] = m_pend[k];
        chk({tag, "/take"}, int'(o_irq_take), int'(m_take));
        if (m_take) chk({tag, "/vector"}, int'(o_irq_vector), m_vec);
        chk({tag, "/depth"}, int'(o_irq_depth), m_stk.size());
        chk({tag, "/in_irq"}, int'(o_in_irq), int'(m_stk.size() > 0));
        chk({tag, "/pending"}, int'(o_pending), int'(mp));
        chk({tag, "/depth_limit"}, int'(o_irq_depth <= 2'(LIMIT)), 1);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge i_clk);
        @(negedge i_clk);
        check_all(tag);
    endtask

    task automatic pulse_src(input int k, input string tag);
        i_irq_src[k] = 1'b1; step(tag);
        i_irq_src[k] = 1'b0; step(tag);
    endtask

    task automatic do_iret(input string tag);
        i_iret = 1'b1; step(tag);
        i_iret = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        i_rst = 1'b1; i_irq_src = '0; i_irq_en = 4'hF; i_gie = 1'b1;
        i_take_ok = 1'b1; i_iret = 1'b0; i_pend_clr = '0;
        @(negedge i_clk);
        idle(2, "reset");
        chk("reset/depth_const", int'(o_irq_depth), 0);
        chk("reset/take_const", int'(o_irq_take), 0);
        i_rst = 1'b0;

        // Single take from source 0.
        pulse_src(0, "s1");
        chk("s1/take_const", int'(o_irq_take), 1);
        chk("s1/vector_const", int'(o_irq_vector), 16'h0020);
        chk("s1/depth_pre", int'(o_irq_depth), 0);
        step("s1c");
        chk("s1/depth_post", int'(o_irq_depth), 1);

        // Source 1 while in source 0: preempts only with nesting enabled.
        pulse_src(1, "s2");
        idle(2, "s2");
        do_iret("s2r");
        idle(3, "s2");
        do_iret("s2r");
        do_iret("s2r");
        idle(2, "s2");

        // Lower priority blocked while source 1 is active.
        pulse_src(1, "s3");
        idle(1, "s3");
        pulse_src(0, "s3");
        idle(2, "s3");
        do_iret("s3r");
        idle(3, "s3");
        do_iret("s3r");
        idle(1, "s3");

        // Simultaneous 0 and 2 with source 2 masked.
        i_irq_en = 4'b1011;
        i_irq_src = 4'b0101; step("s4");
        i_irq_src = 4'b0000; idle(3, "s4");
        do_iret("s4r");
        idle(2, "s4");
        i_irq_en = 4'hF;
        idle(3, "s4");
        do_iret("s4r");
        idle(1, "s4");

        // Global disable, clear-vs-set, spurious iret, depth saturation.
        i_gie = 1'b0;
        pulse_src(3, "s5gie");
        idle(2, "s5gie");
        i_pend_clr = 4'b1000; step("s5clr");
        i_pend_clr = 4'b0001; i_irq_src[0] = 1'b1; step("s5same");
        i_pend_clr = '0; i_irq_src[0] = 1'b0;
        i_pend_clr = 4'b0001; step("s5clr"); i_pend_clr = '0;
        i_gie = 1'b1;
        do_iret("s5iret0");
        pulse_src(0, "s5max"); idle(1, "s5max");
        pulse_src(1, "s5max"); idle(1, "s5max");
        pulse_src(2, "s5max"); idle(1, "s5max");
        pulse_src(3, "s5max"); idle(3, "s5max");
        for (int i = 0; i < 4; i++) begin do_iret("s5unw"); idle(2, "s5unw"); end
        idle(2, "s5");

        // Reset landing on the take pulse.
        pulse_src(2, "s6");
        i_rst = 1'b1; step("s6rst");
        chk("s6/depth_const", int'(o_irq_depth), 0);
        chk("s6/pending_const", int'(o_pending), 0);
        i_rst = 1'b0; idle(1, "s6");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            i_irq_src  = 4'($urandom);
            i_irq_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            i_gie      = ($urandom_range(0, 7) != 0);
            i_take_ok  = ($urandom_range(0, 3) != 0);
            i_iret     = ($urandom_range(0, 4) == 0);
            i_pend_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            i_rst      = ($urandom_range(0, 99) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
